dcache_dump_unit: RTL and testbench
===================================

// Module: dcache_dump_unit
// PURPOSE
//  Reads a contiguous word range out of the data cache after a run and streams it out
//  over a valid/ready interface. Outputs are {addr, data, last} beats, consumed by a bench
//  monitor or a host link. It is the read-out end of the cache-image path: init files load
//  the caches, this block unloads the data cache. Sits beside the dcache on a spare
//  synchronous read port.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width of the dcache read port
//  DATA_WIDTH  32  dcache word width
// PORTS
//  clk          in   1             clock; all logic on posedge
//  rst          in   1             reset, asynchronous, active-high
//  start        in   1             1-cycle request; sampled only in IDLE
//  base_addr    in   ADDR_WIDTH    first word address, captured with start
//  word_count   in   ADDR_WIDTH+1  number of words to dump, captured with start (0..2^ADDR_WIDTH)
//  busy         out  1             high from the cycle after start until done
//  done         out  1             1-cycle pulse after the last beat handshakes (or immediately for count 0)
//  mem_rd_en    out  1             dcache read strobe
//  mem_rd_addr  out  ADDR_WIDTH    dcache read address
//  mem_rd_data  in   DATA_WIDTH    dcache read data, valid exactly 1 cycle after mem_rd_en
//  out_valid    out  1             stream beat valid
//  out_ready    in   1             stream sink ready
//  out_addr     out  ADDR_WIDTH    word address of the current beat
//  out_data     out  DATA_WIDTH    word data of the current beat
//  out_last     out  1             high on the final beat of the dump
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, mem_rd_en, out_valid and out_last are 0; mem_rd_addr,
//    out_addr and out_data are 0; FIFO empty. Reset mid-dump aborts with no further beats.
//  - FSM states: IDLE, READ, DRAIN, DONE.
//    IDLE->READ on start with word_count!=0. IDLE->DONE on start with word_count==0.
//    READ->DRAIN in the cycle the last read issues. DRAIN->DONE when the last beat
//    handshakes. DONE->IDLE after 1 cycle; done=1 only in DONE.
//  - Read issue: mem_rd_en=1 in READ only when credit is available, i.e. FIFO occupancy plus
//    in-flight reads is less than 2. rd_addr increments by 1 per issue and wraps modulo
//    2^ADDR_WIDTH (base 0x3FF, count 2 -> 0x3FF, 0x000). The remaining-read counter
//    decrements per issue.
//  - The returned word is pushed into a 2-entry FIFO the cycle after issue, together with its
//    address and a last flag. The last flag is set on the word_count-th read.
//  - Stream: out_* are driven from the FIFO head. A beat transfers when out_valid & out_ready.
//    out_addr, out_data and out_last are held stable while out_valid & !out_ready.
//  - Throughput is 1 beat/cycle with out_ready held high. First out_valid appears 2 cycles
//    after start (start in cycle 0; cycle 1 READ issues; cycle 2 data pushed and visible).
//  - Backpressure never drops or duplicates a word; the credit rule prevents FIFO overflow.
//  - A simultaneous FIFO push and pop leaves occupancy unchanged.
//  - start while busy is ignored, as are base_addr and word_count outside IDLE.
//  - Counters are ADDR_WIDTH+1 bits, so word_count=2^ADDR_WIDTH dumps the whole cache.
// STRUCTURE
//  - Shared header dump_defs.vh: FSM state encodings (2-bit) and the beat field order
//    {addr,data,last}.
//  - One sub-module dump_fifo2: 2-entry synchronous FIFO, width ADDR_WIDTH+DATA_WIDTH+1.
//    Ports: push, pop, din, dout, count[1:0]; async active-high reset.
//  - Top contains the FSM, the address and remaining counters, the in-flight flag and the
//    credit logic.
// TESTING
//  1. base=0x010, count=4, out_ready=1, mem holds addr*3
//     -> beats (0x010,0x30), (0x011,0x33), (0x012,0x36), (0x013,0x39) on consecutive cycles;
//        last on beat 4; done 1 cycle after.
//  2. Same dump with out_ready toggling 1,0,0,1,...
//     -> identical 4 beats in order; out_* stable while stalled; mem_rd_en never raised with
//        credit 0.
//  3. base=0x3FE, count=3 -> addresses 0x3FE, 0x3FF, 0x000 (wrap); last on 0x000.
//  4. count=0 -> no mem_rd_en, no out_valid; done pulses 1 cycle after start.
//  5. Second start during a busy dump, base=0x100 -> ignored; only the first range streams.
//  6. rst asserted after beat 2 of a count=8 dump
//     -> all outputs to reset values within the same cycle; no further beats; a new start
//        works normally.

Source files
------------

// File: rtl/dcache_dump_unit_pkg.sv
// Shared definitions for the data-cache dump unit: FSM encoding, default widths
// and the beat field order {addr, data, last}.
package dcache_dump_unit_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

    // A beat is packed as {addr, data, last}
    function automatic int unsigned beat_width(input int unsigned aw, input int unsigned dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/dcache_dump_unit_fifo2.sv
// Two-entry beat FIFO; a word pushed into an empty FIFO is visible on dout in the
// same cycle, so a push and pop together on an empty FIFO never occupy storage.
module dcache_dump_unit_fifo2 #(
    parameter int unsigned WIDTH = 43
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_empty;
    logic w_bypass;
    logic w_write;
    logic w_pop_stored;

    assign w_empty      = (r_count == 2'd0);
    assign w_bypass     = w_empty & push;
    assign w_write      = push & ~(w_empty & pop);
    assign w_pop_stored = pop & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_stored) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_write) - 2'(w_pop_stored);
        end
    end

    assign dout  = w_bypass ? din : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/dcache_dump_unit.sv
// Streams a contiguous word range out of the data cache as {addr, data, last} beats
// over valid/ready, using a spare synchronous read port on the dcache.
module dcache_dump_unit
    import dcache_dump_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned BEAT_W = beat_width(ADDR_WIDTH, DATA_WIDTH);

    dump_state_t r_state;
    dump_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [CNT_W-1:0]      r_remaining;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;
    logic                  r_inflight_last;

    logic [1:0]        w_fifo_count;
    logic [BEAT_W-1:0] w_fifo_din;
    logic [BEAT_W-1:0] w_fifo_dout;
    logic              w_credit;
    logic              w_issue;
    logic              w_pop;
    logic              w_last_issue;

    // Credit: stored beats plus the read in flight must leave room in the FIFO
    assign w_credit     = (3'(w_fifo_count) + 3'(r_inflight)) < 3'd2;
    assign w_issue      = (r_state == ST_READ) && w_credit;
    assign w_last_issue = w_issue && (r_remaining == CNT_W'(1));

    assign w_fifo_din = {r_inflight_addr, mem_rd_data, r_inflight_last};
    assign out_valid  = (w_fifo_count != 2'd0) || r_inflight;
    assign {out_addr, out_data, out_last} = w_fifo_dout;
    assign w_pop      = out_valid & out_ready;
    assign mem_rd_addr = r_rd_addr;

    dcache_dump_unit_fifo2 #(
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && out_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        case (r_state)
            ST_READ: begin
                busy      = 1'b1;
                mem_rd_en = w_issue;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Range capture, address/remaining counters and the one-deep read pipeline tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr       <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_rd_addr   <= base_addr;
                r_remaining <= word_count;
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_rd_addr;
                r_inflight_last <= w_last_issue;
            end
        end
    end

endmodule

// File: tb/tb_dcache_dump_unit.sv
// Directed bench for dcache_dump_unit: a synchronous read-port model holding addr*3,
// and per-cycle checks of beats, stalls, read credit, done timing and reset abort.
module tb_dcache_dump_unit;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    int vectors     = 0;
    int miscompares = 0;

    dcache_dump_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous read port: word at address a holds a*3
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= 32'(mem_rd_addr) * 32'd3;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},      64'(busy),        64'd0);
        check({tag, ".done"},      64'(done),        64'd0);
        check({tag, ".mem_rd_en"}, 64'(mem_rd_en),   64'd0);
        check({tag, ".rd_addr"},   64'(mem_rd_addr), 64'd0);
        check({tag, ".out_valid"}, 64'(out_valid),   64'd0);
        check({tag, ".out_addr"},  64'(out_addr),    64'd0);
        check({tag, ".out_data"},  64'(out_data),    64'd0);
        check({tag, ".out_last"},  64'(out_last),    64'd0);
    endtask

    // One dump: start in cycle 0, then per-cycle checks until done or budget expiry.
    // stall applies ready pattern 1,0,0,1 from cycle 2; stray fires a second start in
    // cycle 2; abort_after>0 asserts rst once that many beats have transferred.
    task automatic run_dump(input string tag, input logic [AW-1:0] base, input logic [AW:0] cnt,
                            input bit stall, input bit stray, input int abort_after);
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        logic          h_last;
        bit            held       = 1'b0;
        bit            done_seen  = 1'b0;
        int            taken      = 0;
        int            issued     = 0;
        int            last_cycle = (cnt == '0) ? 0 : -1;
        int            first_valid = -1;
        bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        out_ready  = 1'b1;
        next_cycle();
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;

        for (int c = 1; c < 120 && !done_seen; c++) begin
            if (abort_after > 0 && taken == abort_after) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({tag, ".abort"});
                return;
            end
            if (stray && c == 2) begin
                start      = 1'b1;
                base_addr  = 10'h100;
                word_count = 11'd5;
            end else begin
                start      = 1'b0;
                base_addr  = '0;
                word_count = '0;
            end
            out_ready = (stall && c >= 2) ? pat[(c - 2) % 4] : 1'b1;
            #1;

            if (c == 1 && cnt != '0) check({tag, ".busy_c1"}, 64'(busy), 64'd1);
            if (last_cycle >= 0 && c == last_cycle + 1) begin
                check({tag, ".done"},      64'(done), 64'd1);
                check({tag, ".busy_done"}, 64'(busy), 64'd0);
                done_seen = 1'b1;
            end else begin
                check({tag, ".done_low"}, 64'(done), 64'd0);
            end

            check({tag, ".credit"}, 64'(mem_rd_en && (issued - taken) >= 2), 64'd0);
            if (mem_rd_en) begin
                check({tag, ".rd_addr"}, 64'(mem_rd_addr), 64'(AW'(base + AW'(issued))));
                check({tag, ".rd_extra"}, 64'(issued < int'(cnt)), 64'd1);
                issued++;
            end

            if (held) begin
                check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, ".hold_addr"},  64'(out_addr),  64'(h_addr));
                check({tag, ".hold_data"},  64'(out_data),  64'(h_data));
                check({tag, ".hold_last"},  64'(out_last),  64'(h_last));
            end

            if (taken >= int'(cnt)) begin
                check({tag, ".extra_valid"}, 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                exp_addr = AW'(base + AW'(taken));
                check({tag, ".addr"}, 64'(out_addr), 64'(exp_addr));
                check({tag, ".data"}, 64'(out_data), 64'(32'(exp_addr) * 32'd3));
                check({tag, ".last"}, 64'(out_last), 64'(taken == int'(cnt) - 1));
                if (out_ready) begin
                    if (taken == int'(cnt) - 1) last_cycle = c;
                    taken++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    h_addr = out_addr;
                    h_data = out_data;
                    h_last = out_last;
                end
            end
            next_cycle();
        end

        if (!done_seen) check({tag, ".timeout"}, 64'd0, 64'd1);
        check({tag, ".beats"}, 64'(taken), 64'(cnt));
        if (!stall && cnt != '0) begin
            check({tag, ".first_valid"}, 64'(first_valid), 64'd2);
            check({tag, ".done_cycle"},  64'(last_cycle),  64'(int'(cnt) + 1));
        end
        check({tag, ".idle_after"}, 64'(busy | done | out_valid | mem_rd_en), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();

        run_dump("basic",   10'h010, 11'd4, 1'b0, 1'b0, 0);
        next_cycle();
        run_dump("stall",   10'h010, 11'd4, 1'b1, 1'b0, 0);
        next_cycle();
        run_dump("wrap",    10'h3FE, 11'd3, 1'b0, 1'b0, 0);
        next_cycle();
        run_dump("wrap2",   10'h3FF, 11'd2, 1'b1, 1'b0, 0);
        next_cycle();
        run_dump("zero",    10'h055, 11'd0, 1'b0, 1'b0, 0);
        next_cycle();
        run_dump("stray",   10'h020, 11'd6, 1'b0, 1'b1, 0);
        next_cycle();
        run_dump("abort",   10'h040, 11'd8, 1'b0, 1'b0, 2);

        next_cycle();
        check_reset_outputs("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("post_abort.valid", 64'(out_valid), 64'd0);
            check("post_abort.rd_en", 64'(mem_rd_en), 64'd0);
            check("post_abort.busy",  64'(busy),      64'd0);
        end
        run_dump("restart", 10'h010, 11'd4, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
